sb_free_list: RTL and testbench

Scoreboard tag free list: a circular FIFO holding every unallocated scoreboard (SB) entry index. It sits directly upstream of issue-queue assignment. Each cycle it supplies at most one free SB tag to the dispatch/assign path and accepts at most one released tag from commit. It tracks list membership in a bitmap so that illegal frees are dropped rather than corrupting the list, and it restores the full list on pipeline flush.

---
 rtl/sb_free_list.sv | 109 ++++++++++
 tb/tb_sb_free_list.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sb_free_list.sv
// Scoreboard tag free list: circular FIFO of unallocated SB tags.
// It provides one tag per cycle to dispatch and takes one released tag per
// cycle from commit. A membership bitmap rejects double frees and frees
// while full, and raises a sticky error when it does.
module sb_free_list #(
    parameter int SB_DEPTH = 8,
    parameter int SB       = $clog2(SB_DEPTH)
) (
    input  logic          clk,
    input  logic          reset_,
    input  logic          flush,
    input  logic          alloc_req,
    output logic          alloc_ready,
    output logic [SB-1:0] alloc_tag,
    input  logic          free_valid,
    input  logic [SB-1:0] free_tag,
    output logic [SB:0]   free_count,
    output logic          err
);

    localparam logic [SB:0] FULL_CNT = (SB+1)'(SB_DEPTH);
    localparam logic [SB:0] PTR_ONE  = (SB+1)'(1);

    logic [SB-1:0]       tag_q [SB_DEPTH];
    logic [SB-1:0]       tag_d [SB_DEPTH];
    logic [SB:0]         head_q, head_d;
    logic [SB:0]         tail_q, tail_d;
    logic [SB_DEPTH-1:0] in_list_q, in_list_d;
    logic                err_q, err_d;

    logic [SB:0]         count_s;
    logic                grant_s;
    logic                free_legal_s;
    logic                free_illegal_s;

    // Outputs derive from registered state only, so no input-to-output paths.
    always_comb begin
        count_s     = tail_q - head_q;
        alloc_ready = (count_s != {(SB+1){1'b0}});
        alloc_tag   = tag_q[head_q[SB-1:0]];
        free_count  = count_s;
        err         = err_q;
    end

    // Grant and free legality, both judged against the pre-edge state.
    always_comb begin
        grant_s        = alloc_req & alloc_ready & ~flush;
        free_legal_s   = free_valid & ~flush & ~in_list_q[free_tag] &
                         (count_s != FULL_CNT);
        free_illegal_s = free_valid & ~flush & ~free_legal_s;
    end

    // Next-state: flush restores the full list, otherwise apply grant and free.
    always_comb begin
        tag_d     = tag_q;
        head_d    = head_q;
        tail_d    = tail_q;
        in_list_d = in_list_q;
        err_d     = err_q;
        if (flush) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                tag_d[i] = SB'(i);
            end
            head_d    = {(SB+1){1'b0}};
            tail_d    = FULL_CNT;
            in_list_d = {SB_DEPTH{1'b1}};
        end else begin
            if (grant_s) begin
                head_d                 = head_q + PTR_ONE;
                in_list_d[alloc_tag]   = 1'b0;
            end else begin
                head_d = head_q;
            end
            // A legal free never targets the granted tag: that tag is in the list.
            if (free_legal_s) begin
                tag_d[tail_q[SB-1:0]] = free_tag;
                tail_d                = tail_q + PTR_ONE;
                in_list_d[free_tag]   = 1'b1;
            end else begin
                tail_d = tail_q;
            end
            if (free_illegal_s) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
        end
    end

    // State registers; asynchronous reset loads the full list and clears err.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                tag_q[i] <= SB'(i);
            end
            head_q    <= {(SB+1){1'b0}};
            tail_q    <= FULL_CNT;
            in_list_q <= {SB_DEPTH{1'b1}};
            err_q     <= 1'b0;
        end else begin
            tag_q     <= tag_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            in_list_q <= in_list_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_sb_free_list.sv
// Directed bench for sb_free_list with SB_DEPTH=8.
module tb_sb_free_list;

    logic       clk;
    logic       reset_;
    logic       flush;
    logic       alloc_req;
    logic       alloc_ready;
    logic [2:0] alloc_tag;
    logic       free_valid;
    logic [2:0] free_tag;
    logic [3:0] free_count;
    logic       err;

    int checks;
    int errors;

    logic [2:0] list_m [$];
    logic [2:0] owned_m [$];
    logic [2:0] t_v;

    sb_free_list #(.SB_DEPTH(8)) dut (
        .clk         (clk),
        .reset_      (reset_),
        .flush       (flush),
        .alloc_req   (alloc_req),
        .alloc_ready (alloc_ready),
        .alloc_tag   (alloc_tag),
        .free_valid  (free_valid),
        .free_tag    (free_tag),
        .free_count  (free_count),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req  = 1'b0;
        free_valid = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic do_free(input logic [2:0] t);
        alloc_req  = 1'b0;
        free_valid = 1'b1;
        free_tag   = t;
        tick();
        idle();
    endtask

    task automatic pulse_reset();
        #2 reset_ = 1'b0;
        #1;
        check("areset_count", 32'(free_count), 32'd8);
        check("areset_tag", 32'(alloc_tag), 32'd0);
        check("areset_err", 32'(err), 32'd0);
        check("areset_ready", 32'(alloc_ready), 32'd1);
        #2 reset_ = 1'b1;
        tick();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset_     = 1'b0;
        flush      = 1'b0;
        alloc_req  = 1'b0;
        free_valid = 1'b0;
        free_tag   = 3'd0;
        #12;
        check("reset_ready", 32'(alloc_ready), 32'd1);
        check("reset_tag", 32'(alloc_tag), 32'd0);
        check("reset_count", 32'(free_count), 32'd8);
        check("reset_err", 32'(err), 32'd0);
        reset_ = 1'b1;
        tick();

        // Drain: tags 0..7 in order, count 8 down to 0.
        alloc_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_tag", 32'(alloc_tag), 32'(i));
            check("drain_count", 32'(free_count), 32'(8 - i));
            tick();
        end
        check("drained_ready", 32'(alloc_ready), 32'd0);
        check("drained_count", 32'(free_count), 32'd0);
        tick();
        check("ninth_req_count", 32'(free_count), 32'd0);
        check("ninth_req_ready", 32'(alloc_ready), 32'd0);
        check("ninth_req_err", 32'(err), 32'd0);
        idle();

        // Refill scrambled, then allocate in the same order.
        do_free(3'd5);
        check("refill_ready", 32'(alloc_ready), 32'd1);
        check("refill_tag0", 32'(alloc_tag), 32'd5);
        do_free(3'd2);
        do_free(3'd7);
        check("refill_count", 32'(free_count), 32'd3);
        alloc_req = 1'b1;
        check("realloc_5", 32'(alloc_tag), 32'd5);
        tick();
        check("realloc_2", 32'(alloc_tag), 32'd2);
        tick();
        check("realloc_7", 32'(alloc_tag), 32'd7);
        tick();
        idle();
        check("realloc_count", 32'(free_count), 32'd0);

        // Simultaneous alloc+free at free_count=3; empty-list free accepted
        // alongside an ungranted alloc request.
        alloc_req  = 1'b1;
        free_valid = 1'b1;
        free_tag   = 3'd0;
        tick();
        idle();
        check("empty_af_count", 32'(free_count), 32'd1);
        check("empty_af_tag", 32'(alloc_tag), 32'd0);
        do_free(3'd1);
        do_free(3'd2);
        list_m  = '{3'd0, 3'd1, 3'd2};
        owned_m = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        for (int i = 0; i < 20; i++) begin
            alloc_req  = 1'b1;
            free_valid = 1'b1;
            free_tag   = owned_m.pop_front();
            check("steady_tag", 32'(alloc_tag), 32'(list_m[0]));
            check("steady_count", 32'(free_count), 32'd3);
            t_v = list_m.pop_front();
            owned_m.push_back(t_v);
            list_m.push_back(free_tag);
            tick();
        end
        idle();
        check("steady_count_end", 32'(free_count), 32'd3);
        check("steady_err", 32'(err), 32'd0);

        // Flush restores the full list; free while full is illegal.
        flush = 1'b1;
        tick();
        idle();
        check("flush_full_count", 32'(free_count), 32'd8);
        check("flush_full_tag", 32'(alloc_tag), 32'd0);
        check("flush_err_kept", 32'(err), 32'd0);
        do_free(3'd2);
        check("full_free_err", 32'(err), 32'd1);
        check("full_free_count", 32'(free_count), 32'd8);

        // Reset clears err; then free tag 3 while it is still in the list.
        pulse_reset();
        alloc_req = 1'b1;
        tick();
        idle();
        check("one_alloc_count", 32'(free_count), 32'd7);
        check("one_alloc_err", 32'(err), 32'd0);
        do_free(3'd3);
        check("dbl_free_err", 32'(err), 32'd1);
        check("dbl_free_count", 32'(free_count), 32'd7);
        check("dbl_free_tag", 32'(alloc_tag), 32'd1);

        // Flush mid-stream with alloc and free asserted: no grant.
        pulse_reset();
        alloc_req = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("six_alloc_count", 32'(free_count), 32'd2);
        check("six_alloc_tag", 32'(alloc_tag), 32'd6);
        flush      = 1'b1;
        free_valid = 1'b1;
        free_tag   = 3'd0;
        tick();
        flush      = 1'b0;
        free_valid = 1'b0;
        check("mid_flush_count", 32'(free_count), 32'd8);
        check("mid_flush_tag", 32'(alloc_tag), 32'd0);
        check("mid_flush_err", 32'(err), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("post_flush_tag", 32'(alloc_tag), 32'(i));
            tick();
        end
        idle();
        check("post_flush_count", 32'(free_count), 32'd0);

        // Build free_count=2 with err set, then reset between clock edges.
        do_free(3'd3);
        do_free(3'd3);
        do_free(3'd6);
        check("pre_areset_count", 32'(free_count), 32'd2);
        check("pre_areset_err", 32'(err), 32'd1);
        check("pre_areset_tag", 32'(alloc_tag), 32'd3);
        pulse_reset();
        alloc_req = 1'b1;
        check("first_after_reset", 32'(alloc_tag), 32'd0);
        tick();
        check("second_after_reset", 32'(alloc_tag), 32'd1);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
